// File: rtl/sprite_mover.sv
// sprite_mover: steps a sprite's top-left corner in a latched button direction, clamped to the screen and kept out of one obstacle.
// Define SPRITE_MOVER_ACCEL_EN to double the step after ACCEL_TICKS consecutive moves in one direction.
module sprite_mover #(
    parameter int SCREEN_W    = 96,
    parameter int SCREEN_H    = 64,
    parameter int SPRITE_SIZE = 9,
    parameter int START_X     = 0,
    parameter int START_Y     = 54,
    parameter int OBS_X0      = 57,
    parameter int OBS_X1      = 95,
    parameter int OBS_Y0      = 0,
    parameter int OBS_Y1      = 29,
    parameter int STEP        = 1,
    parameter int ACCEL_TICKS = 15
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        move_tick,
    input  logic [3:0]                  pb,
    output logic [$clog2(SCREEN_W)-1:0] pos_x,
    output logic [$clog2(SCREEN_H)-1:0] pos_y,
    output logic [3:0]                  dir,
    output logic                        blocked,
    output logic                        fast
);
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    typedef logic [XW-1:0] px_t;
    typedef logic [YW-1:0] py_t;
    typedef logic [XW:0]   wx_t;
    typedef logic [YW:0]   wy_t;
    localparam wx_t XMAX = wx_t'(SCREEN_W - SPRITE_SIZE);
    localparam wy_t YMAX = wy_t'(SCREEN_H - SPRITE_SIZE);
    localparam wx_t SZX  = wx_t'(SPRITE_SIZE);
    localparam wy_t SZY  = wy_t'(SPRITE_SIZE);
    localparam wx_t OX0  = wx_t'(OBS_X0);
    localparam wx_t OX1P = wx_t'(OBS_X1 + 1);
    localparam wy_t OY0  = wy_t'(OBS_Y0);
    localparam wy_t OY1P = wy_t'(OBS_Y1 + 1);
    localparam wx_t STX  = wx_t'(STEP);
    localparam wy_t STY  = wy_t'(STEP);

    px_t pos_x_q, pos_x_d;
    py_t pos_y_q, pos_y_d;
    logic [3:0] dir_q, dir_d;
    logic blocked_q, blocked_d, fast_q, fast_d;
    wx_t xw, sx, cx;
    wy_t yw, sy, cy;
    logic go, ovl, refuse;

    always_comb begin
        dir_d = !enable ? 4'b0000 : pb[0] ? 4'b0001 : pb[1] ? 4'b0010 :
                pb[2] ? 4'b0100 : pb[3] ? 4'b1000 : dir_q;
        xw = {1'b0, pos_x_q};
        yw = {1'b0, pos_y_q};
        sx = fast_q ? STX << 1 : STX;
        sy = fast_q ? STY << 1 : STY;
        cx = dir_q[2] ? (xw < sx ? '0 : xw - sx) :
             dir_q[3] ? (xw + sx > XMAX ? XMAX : xw + sx) : xw;
        cy = dir_q[0] ? (yw < sy ? '0 : yw - sy) :
             dir_q[1] ? (yw + sy > YMAX ? YMAX : yw + sy) : yw;
        // inclusive bounds rewritten as strict compares so no term can go negative
        ovl = cx < OX1P && cx + SZX > OX0 && cy < OY1P && cy + SZY > OY0;
        go = enable && move_tick && dir_q != 4'b0000;
        refuse = go && ((cx == xw && cy == yw) || ovl);
        pos_x_d = !enable ? px_t'(START_X) : go && !refuse ? cx[XW-1:0] : pos_x_q;
        pos_y_d = !enable ? py_t'(START_Y) : go && !refuse ? cy[YW-1:0] : pos_y_q;
        blocked_d = refuse;
    end

`ifdef SPRITE_MOVER_ACCEL_EN
    localparam int CW = $clog2(ACCEL_TICKS + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (!enable || refuse || dir_d != dir_q) ? '0 :
                (go && cnt_q != CW'(ACCEL_TICKS)) ? cnt_q + CW'(1) : cnt_q;
        fast_d = cnt_d == CW'(ACCEL_TICKS);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign fast_d = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q   <= px_t'(START_X);
            pos_y_q   <= py_t'(START_Y);
            dir_q     <= 4'b0000;
            blocked_q <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            blocked_q <= blocked_d;
            fast_q    <= fast_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign blocked = blocked_q;
    assign fast    = fast_q;
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed stimulus for sprite_mover, checked every cycle against a plain integer model plus literal pins.
module tb_sprite_mover;
    localparam int A = 4;
    logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0, move_tick = 1'b0;
    logic [3:0] pb = 4'b0000;
    logic [6:0] pos_x;
    logic [5:0] pos_y;
    logic [3:0] dir;
    logic blocked, fast;
    int total = 0, bad = 0;
    int mx = 0, my = 54, mdir = 0, nd, s, nx, ny;
    bit mfast = 0, mblk = 0, moved;
`ifdef SPRITE_MOVER_ACCEL_EN
    int mcnt = 0;
`endif

    sprite_mover #(.ACCEL_TICKS(A)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .move_tick(move_tick), .pb(pb),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .blocked(blocked), .fast(fast)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit hits(input int x, input int y);
        return x <= 95 && x + 8 >= 57 && y <= 29 && y + 8 >= 0;
    endfunction

    // reference model: integer screen coordinates, updated on every edge
    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n || !enable) begin
            mx = 0; my = 54; mdir = 0; mfast = 0; mblk = 0;
`ifdef SPRITE_MOVER_ACCEL_EN
            mcnt = 0;
`endif
        end else begin
            nd = mdir;
            for (int i = 3; i >= 0; i--) if (pb[i]) nd = 1 << i;
            moved = 0; mblk = 0;
            if (move_tick && mdir != 0) begin
                s = mfast ? 2 : 1;
                nx = mx; ny = my;
                if (mdir == 1) ny = (my - s < 0) ? 0 : my - s;
                if (mdir == 2) ny = (my + s > 55) ? 55 : my + s;
                if (mdir == 4) nx = (mx - s < 0) ? 0 : mx - s;
                if (mdir == 8) nx = (mx + s > 87) ? 87 : mx + s;
                if ((nx == mx && ny == my) || hits(nx, ny)) mblk = 1;
                else begin mx = nx; my = ny; moved = 1; end
            end
`ifdef SPRITE_MOVER_ACCEL_EN
            if (nd != mdir || mblk) mcnt = 0;
            else if (moved && mcnt < A) mcnt++;
            mfast = mcnt >= A;
`endif
            mdir = nd;
        end
    end

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            chk("model_x", int'(pos_x), mx);
            chk("model_y", int'(pos_y), my);
            chk("model_dir", int'(dir), mdir);
            chk("model_blocked", int'(blocked), int'(mblk));
            chk("model_fast", int'(fast), int'(mfast));
        end
    end

    task automatic press(input logic [3:0] p);
        pb = p; @(negedge clock); pb = 4'b0000;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin move_tick = 1'b1; @(negedge clock); move_tick = 1'b0; end
    endtask

    task automatic rehome;
        enable = 1'b0; @(negedge clock); enable = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        chk("rst_x", int'(pos_x), 0);
        chk("rst_y", int'(pos_y), 54);
        chk("rst_dir", int'(dir), 0);
        chk("rst_blocked", int'(blocked), 0);
        chk("rst_fast", int'(fast), 0);
        reset_n = 1'b1; enable = 1'b1;
        @(negedge clock);
`ifndef SPRITE_MOVER_ACCEL_EN
        press(4'b0100);
        chk("dir_left", int'(dir), 4);
        ticks(1);
        chk("left_edge_blk", int'(blocked), 1);
        chk("left_edge_x", int'(pos_x), 0);
        @(negedge clock);
        chk("blk_one_cycle", int'(blocked), 0);
        rehome; press(4'b0001); ticks(54);
        chk("up_top_y", int'(pos_y), 0);
        chk("up_top_noblk", int'(blocked), 0);
        ticks(1);
        chk("up_top_blk", int'(blocked), 1);
        chk("up_top_hold", int'(pos_y), 0);
        rehome; press(4'b1000); ticks(87);
        chk("right_x87", int'(pos_x), 87);
        ticks(1);
        chk("right_edge_blk", int'(blocked), 1);
        press(4'b0001); ticks(24);
        chk("obs_y30", int'(pos_y), 30);
        ticks(1);
        chk("obs_blk", int'(blocked), 1);
        chk("obs_hold_y", int'(pos_y), 30);
        rehome; press(4'b1111);
        chk("prio_up", int'(dir), 1);
        pb = 4'b1000; move_tick = 1'b1; @(negedge clock); pb = 4'b0000; move_tick = 1'b0;
        chk("same_cycle_y", int'(pos_y), 53);
        chk("same_cycle_dir", int'(dir), 8);
        ticks(1);
        chk("next_tick_x", int'(pos_x), 1);
        rehome; press(4'b1000); ticks(40); press(4'b0001); ticks(34);
        chk("at40_x", int'(pos_x), 40);
        chk("at20_y", int'(pos_y), 20);
        enable = 1'b0; move_tick = 1'b1; @(negedge clock); move_tick = 1'b0;
        chk("dis_x", int'(pos_x), 0);
        chk("dis_y", int'(pos_y), 54);
        chk("dis_dir", int'(dir), 0);
        ticks(3);
        chk("dis_ticks_y", int'(pos_y), 54);
        enable = 1'b1;
`else
        rehome; press(4'b1000); ticks(3);
        chk("acc_slow", int'(fast), 0);
        ticks(1);
        chk("acc_x4", int'(pos_x), 4);
        chk("acc_fast", int'(fast), 1);
        ticks(1);
        chk("acc_x6", int'(pos_x), 6);
        ticks(40);
        chk("acc_x86", int'(pos_x), 86);
        ticks(1);
        chk("acc_x87", int'(pos_x), 87);
        chk("acc_still_fast", int'(fast), 1);
        press(4'b0100);
        chk("acc_dir_clear", int'(fast), 0);
        press(4'b1000); ticks(1);
        chk("acc_edge_blk", int'(blocked), 1);
        chk("acc_edge_x", int'(pos_x), 87);
`endif
        press(4'b0010); ticks(1);
        chk("pre_rst_y", int'(pos_y), 55);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_y", int'(pos_y), 54);
        chk("async_rst_x", int'(pos_x), 0);
        chk("async_rst_dir", int'(dir), 0);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock); @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
